// File: rtl/sprite_motion_pkg.sv
// Shared types and geometry for the sprite motion controller.
//   motion_state_t : vertical motion state (GROUND / RISE / FALL)
//   DEF_*          : default geometry constants
//   y_ground/x_max : derived clamp limits for the sprite top-left corner
package sprite_motion_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } motion_state_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_SPRITE_W = 5;
  localparam int unsigned DEF_SPRITE_H = 5;

  // Lowest legal top edge: sprite bottom row sits on the last active line.
  function automatic int unsigned y_ground(input int unsigned v_active,
                                           input int unsigned sprite_h);
    return v_active - sprite_h;
  endfunction

  // Rightmost legal left edge: sprite right column on the last active pixel.
  function automatic int unsigned x_max(input int unsigned h_active,
                                        input int unsigned sprite_w);
    return h_active - sprite_w;
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_frame_tick_gen.sv
// Frame strobe generator: registers the active-low vertical sync and flags
// its falling edge. Shared with VGA-side logic needing a per-frame strobe.
//   i_clk  : system clock
//   i_rst  : synchronous active-high reset (sync history forced high)
//   i_vs   : vertical sync, active low, synchronous to i_clk
//   o_tick : high in the cycle i_vs is first sampled low
module frame_tick_gen (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vs,
  output logic o_tick
);

  logic vs_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_q <= 1'b1;
    end else begin
      vs_q <= i_vs;
    end
  end

  assign o_tick = vs_q & ~i_vs;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-player sprite motion: once per video frame (falling edge of i_vs)
// applies horizontal walking and a jump/gravity vertical state machine.
// Buttons pressed at any time during the frame are latched until the tick.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_vs          : active-low vertical sync from the VGA stage
//   i_left/right  : walk buttons, i_jump : jump button (active high)
//   o_x_pos/o_y_pos : sprite top-left corner in active-area pixels
//   o_frame_tick  : one-cycle pulse coincident with a position update
//   o_state       : 0=GROUND 1=RISE 2=FALL, o_vy : speed magnitude (debug)
// Optional: define SPRITE_MOTION_DOUBLE_JUMP_EN to allow one airborne jump
// per flight.
module sprite_motion_ctrl
  import sprite_motion_pkg::*;
#(
  parameter int unsigned C_H_ACTIVE_TIME = DEF_H_ACTIVE,
  parameter int unsigned C_V_ACTIVE_TIME = DEF_V_ACTIVE,
  parameter int unsigned C_SPRITE_W      = DEF_SPRITE_W,
  parameter int unsigned C_SPRITE_H      = DEF_SPRITE_H,
  parameter int unsigned X_INIT          = 0,
  parameter int unsigned STEP_X          = 2,
  parameter int unsigned JUMP_V          = 12,
  parameter int unsigned GRAVITY         = 1,
  parameter int unsigned VY_MAX          = 12
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_vs,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_jump,
  output logic [9:0] o_x_pos,
  output logic [9:0] o_y_pos,
  output logic       o_frame_tick,
  output logic [1:0] o_state,
  output logic [3:0] o_vy
);

  localparam logic [9:0]  Y_GROUND = 10'(y_ground(C_V_ACTIVE_TIME, C_SPRITE_H));
  localparam logic [10:0] X_MAX_S  = 11'(x_max(C_H_ACTIVE_TIME, C_SPRITE_W));
  localparam logic [10:0] STEP_S   = 11'(STEP_X);
  localparam logic [9:0]  JV10     = 10'(JUMP_V);
  localparam logic [3:0]  JV_NEXT  = 4'(JUMP_V - GRAVITY);
  localparam logic [3:0]  GRAV4    = 4'(GRAVITY);
  localparam logic [4:0]  GRAV5    = 5'(GRAVITY);
  localparam logic [4:0]  VYMAX5   = 5'(VY_MAX);

  logic tick;

  frame_tick_gen u_frame_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_vs   (i_vs),
    .o_tick (tick)
  );

  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [3:0]    vy_q, vy_d;
  motion_state_t state_q, state_d;
  logic          tick_q;
  logic          left_q, right_q, jump_q;
  logic          left_e, right_e, jump_e;

`ifdef SPRITE_MOTION_DOUBLE_JUMP_EN
  logic dj_q, dj_d;
`endif

  // A press in the tick cycle itself still counts.
  assign left_e  = left_q  | i_left;
  assign right_e = right_q | i_right;
  assign jump_e  = jump_q  | i_jump;

  // Horizontal: 11-bit signed so a step below zero is seen before clamping.
  logic signed [10:0] x_s;

  always_comb begin
    x_s = $signed({1'b0, x_q});
    x_d = x_q;
    if (left_e && !right_e) begin
      x_s = $signed({1'b0, x_q}) - $signed(STEP_S);
      x_d = (x_s < 0) ? '0 : x_s[9:0];
    end else if (right_e && !left_e) begin
      x_s = $signed({1'b0, x_q}) + $signed(STEP_S);
      x_d = (x_s > $signed(X_MAX_S)) ? X_MAX_S[9:0] : x_s[9:0];
    end
  end

  // Vertical state machine.
  logic [4:0]  vy_sum;
  logic [3:0]  vy_fall;
  logic [10:0] y_fall;

  always_comb begin
    vy_sum  = {1'b0, vy_q} + GRAV5;
    vy_fall = (vy_sum > VYMAX5) ? VYMAX5[3:0] : vy_sum[3:0];
    y_fall  = {1'b0, y_q} + {7'd0, vy_fall};
    y_d     = y_q;
    vy_d    = vy_q;
    state_d = state_q;
`ifdef SPRITE_MOTION_DOUBLE_JUMP_EN
    dj_d    = dj_q;
`endif
    case (state_q)
      GROUND: begin
        if (jump_e) begin
          y_d     = Y_GROUND - JV10;
          vy_d    = JV_NEXT;
          state_d = RISE;
        end else begin
          y_d = Y_GROUND;
        end
      end
      RISE: begin
        if (vy_q == '0) begin
          state_d = FALL;
        end else if (y_q < {6'd0, vy_q}) begin
          y_d     = '0;
          vy_d    = '0;
          state_d = FALL;
        end else begin
          y_d  = y_q - {6'd0, vy_q};
          vy_d = (vy_q <= GRAV4) ? '0 : vy_q - GRAV4;
        end
      end
      FALL: begin
        if (y_fall >= {1'b0, Y_GROUND}) begin
          y_d     = Y_GROUND;
          vy_d    = '0;
          state_d = GROUND;
`ifdef SPRITE_MOTION_DOUBLE_JUMP_EN
          dj_d    = 1'b0;
`endif
        end else begin
          y_d  = y_fall[9:0];
          vy_d = vy_fall;
        end
      end
      default: begin
        y_d     = Y_GROUND;
        vy_d    = '0;
        state_d = GROUND;
      end
    endcase
`ifdef SPRITE_MOTION_DOUBLE_JUMP_EN
    // Airborne jump overrides the normal RISE/FALL update.
    if (state_q != GROUND && jump_e && !dj_q) begin
      y_d     = (y_q < JV10) ? '0 : y_q - JV10;
      vy_d    = JV_NEXT;
      state_d = RISE;
      dj_d    = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q     <= 10'(X_INIT);
      y_q     <= Y_GROUND;
      vy_q    <= '0;
      state_q <= GROUND;
      tick_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      jump_q  <= 1'b0;
`ifdef SPRITE_MOTION_DOUBLE_JUMP_EN
      dj_q    <= 1'b0;
`endif
    end else begin
      tick_q <= tick;
      if (tick) begin
        x_q     <= x_d;
        y_q     <= y_d;
        vy_q    <= vy_d;
        state_q <= state_d;
        left_q  <= 1'b0;
        right_q <= 1'b0;
        jump_q  <= 1'b0;
`ifdef SPRITE_MOTION_DOUBLE_JUMP_EN
        dj_q    <= dj_d;
`endif
      end else begin
        left_q  <= left_q  | i_left;
        right_q <= right_q | i_right;
        jump_q  <= jump_q  | i_jump;
      end
    end
  end

  assign o_x_pos      = x_q;
  assign o_y_pos      = y_q;
  assign o_vy         = vy_q;
  assign o_state      = state_q;
  assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: reset, walking with both clamps,
// single-cycle and held jumps, reset mid-flight and (when the build
// defines SPRITE_MOTION_DOUBLE_JUMP_EN) the airborne jump.
module tb_sprite_motion_ctrl;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1, i_vs = 1'b1;
  logic       i_left = 1'b0, i_right = 1'b0, i_jump = 1'b0;
  logic [9:0] o_x_pos, o_y_pos;
  logic       o_frame_tick;
  logic [1:0] o_state;
  logic [3:0] o_vy;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_cnt = 0;
  int wide_cnt = 0;
  logic prev_tick = 1'b0;

  // Hand-computed single-jump trajectory, ticks 1..25.
  logic [9:0] exp_y [25] = '{463, 452, 442, 433, 425, 418, 412, 407, 403, 400,
                             398, 397, 397, 398, 400, 403, 407, 412, 418, 425,
                             433, 442, 452, 463, 475};
  logic [3:0] exp_vy [25] = '{11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0,
                              1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 0};
  logic [1:0] exp_st [25] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1,
                              2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 0};

  always #5 clk = ~clk;

  sprite_motion_ctrl dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_vs         (i_vs),
    .i_left       (i_left),
    .i_right      (i_right),
    .i_jump       (i_jump),
    .o_x_pos      (o_x_pos),
    .o_y_pos      (o_y_pos),
    .o_frame_tick (o_frame_tick),
    .o_state      (o_state),
    .o_vy         (o_vy)
  );

  always @(negedge clk) begin
    if (o_frame_tick) begin
      tick_cnt++;
      if (prev_tick) wide_cnt++;
    end
    prev_tick = o_frame_tick;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One frame: buttons held (jp adds a jump in the first cycle only),
  // vsync high for 3 cycles, then low; returns just after the tick edge.
  task automatic frame(input logic l, input logic r, input logic j, input logic jp);
    i_left = l; i_right = r; i_jump = j | jp; i_vs = 1'b1;
    cyc();
    i_jump = j;
    cyc();
    cyc();
    i_vs = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_vs = 1'b1;
    cyc(); cyc();
    i_rst = 1'b0;
    n_cmp++;
    if (o_x_pos !== 10'd0 || o_y_pos !== 10'd475 || o_state !== 2'd0 ||
        o_vy !== 4'd0 || o_frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: x=%0d y=%0d st=%0d vy=%0d tick=%0d, want 0 475 0 0 0",
               o_x_pos, o_y_pos, o_state, o_vy, o_frame_tick);
    end
    tick_cnt = 0; wide_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      frame(1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (o_frame_tick !== 1'b1) begin
        n_bad++;
        $display("FAIL tick_pulse[%0d]: got %0d want 1", i, o_frame_tick);
      end
    end
    i_vs = 1'b1;
    cyc();
    n_cmp++;
    if (o_frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL tick_after: got %0d want 0", o_frame_tick);
    end
    n_cmp++;
    if (o_x_pos !== 10'd0 || o_y_pos !== 10'd475 || o_state !== 2'd0) begin
      n_bad++;
      $display("FAIL idle_frames: x=%0d y=%0d st=%0d, want 0 475 0", o_x_pos, o_y_pos, o_state);
    end
    n_cmp++;
    if (tick_cnt !== 3 || wide_cnt !== 0) begin
      n_bad++;
      $display("FAIL tick_count: count=%0d wide=%0d, want 3 0", tick_cnt, wide_cnt);
    end
  endtask

  task automatic test_walk();
    int ex;
    for (int i = 1; i <= 400; i++) begin
      frame(1'b0, 1'b1, 1'b0, 1'b0);
      ex = (2 * i > 635) ? 635 : 2 * i;
      n_cmp++;
      if (o_x_pos !== ex[9:0]) begin
        n_bad++;
        $display("FAIL walk_right[%0d]: got %0d want %0d", i, o_x_pos, ex);
      end
    end
    for (int i = 0; i < 3; i++) begin
      frame(1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (o_x_pos !== 10'd635) begin
        n_bad++;
        $display("FAIL walk_both[%0d]: got %0d want 635", i, o_x_pos);
      end
    end
    // From 635 odd steps reach 1, then the next step underflows to 0.
    for (int i = 1; i <= 320; i++) begin
      frame(1'b1, 1'b0, 1'b0, 1'b0);
      ex = (635 - 2 * i < 0) ? 0 : 635 - 2 * i;
      n_cmp++;
      if (o_x_pos !== ex[9:0]) begin
        n_bad++;
        $display("FAIL walk_left[%0d]: got %0d want %0d", i, o_x_pos, ex);
      end
    end
    n_cmp++;
    if (o_y_pos !== 10'd475 || o_state !== 2'd0) begin
      n_bad++;
      $display("FAIL walk_vertical: y=%0d st=%0d, want 475 0", o_y_pos, o_state);
    end
  endtask

  task automatic test_jump_pulse();
    for (int i = 0; i < 25; i++) begin
      frame(1'b0, 1'b0, 1'b0, i == 0);
      n_cmp++;
      if (o_y_pos !== exp_y[i] || o_vy !== exp_vy[i] || o_state !== exp_st[i]) begin
        n_bad++;
        $display("FAIL jump_pulse[tick%0d]: y=%0d vy=%0d st=%0d, want %0d %0d %0d",
                 i + 1, o_y_pos, o_vy, o_state, exp_y[i], exp_vy[i], exp_st[i]);
      end
    end
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_y_pos !== 10'd475 || o_state !== 2'd0) begin
      n_bad++;
      $display("FAIL jump_pulse_rest: y=%0d st=%0d, want 475 0", o_y_pos, o_state);
    end
  endtask

  task automatic test_jump_held();
    for (int i = 0; i < 25; i++) begin
      frame(1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (o_y_pos !== exp_y[i] || o_vy !== exp_vy[i] || o_state !== exp_st[i]) begin
        n_bad++;
        $display("FAIL jump_held[tick%0d]: y=%0d vy=%0d st=%0d, want %0d %0d %0d",
                 i + 1, o_y_pos, o_vy, o_state, exp_y[i], exp_vy[i], exp_st[i]);
      end
    end
    frame(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (o_y_pos !== 10'd463 || o_state !== 2'd1 || o_vy !== 4'd11) begin
      n_bad++;
      $display("FAIL jump_held_rejump: y=%0d st=%0d vy=%0d, want 463 1 11",
               o_y_pos, o_state, o_vy);
    end
    repeat (24) frame(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_y_pos !== 10'd475 || o_state !== 2'd0) begin
      n_bad++;
      $display("FAIL jump_held_land: y=%0d st=%0d, want 475 0", o_y_pos, o_state);
    end
  endtask

  task automatic test_reset_midjump();
    frame(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) frame(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_y_pos !== 10'd425 || o_state !== 2'd1) begin
      n_bad++;
      $display("FAIL midjump_tick5: y=%0d st=%0d, want 425 1", o_y_pos, o_state);
    end
    // Stale presses that reset must discard.
    i_vs = 1'b1; i_right = 1'b1; i_jump = 1'b1;
    cyc();
    i_right = 1'b0; i_jump = 1'b0;
    cyc();
    i_vs = 1'b0; i_rst = 1'b1;
    cyc();
    i_rst = 1'b0; i_vs = 1'b1;
    n_cmp++;
    if (o_x_pos !== 10'd0 || o_y_pos !== 10'd475 || o_state !== 2'd0 ||
        o_vy !== 4'd0 || o_frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_midjump: x=%0d y=%0d st=%0d vy=%0d tick=%0d, want 0 475 0 0 0",
               o_x_pos, o_y_pos, o_state, o_vy, o_frame_tick);
    end
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_x_pos !== 10'd0 || o_y_pos !== 10'd475 || o_state !== 2'd0) begin
      n_bad++;
      $display("FAIL latch_cleared: x=%0d y=%0d st=%0d, want 0 475 0",
               o_x_pos, o_y_pos, o_state);
    end
    // Presses only in the tick cycle.
    i_vs = 1'b1;
    repeat (3) cyc();
    i_vs = 1'b0; i_left = 1'b1;
    cyc();
    i_left = 1'b0;
    n_cmp++;
    if (o_x_pos !== 10'd0 || o_frame_tick !== 1'b1) begin
      n_bad++;
      $display("FAIL tick_cycle_left: x=%0d tick=%0d, want 0 1", o_x_pos, o_frame_tick);
    end
    i_vs = 1'b1;
    repeat (3) cyc();
    i_vs = 1'b0; i_right = 1'b1;
    cyc();
    i_right = 1'b0;
    n_cmp++;
    if (o_x_pos !== 10'd2) begin
      n_bad++;
      $display("FAIL tick_cycle_right: x=%0d, want 2", o_x_pos);
    end
  endtask

`ifdef SPRITE_MOTION_DOUBLE_JUMP_EN
  task automatic test_double_jump();
    frame(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) frame(1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (o_y_pos !== 10'd421 || o_vy !== 4'd11 || o_state !== 2'd1) begin
      n_bad++;
      $display("FAIL double_jump: y=%0d vy=%0d st=%0d, want 421 11 1",
               o_y_pos, o_vy, o_state);
    end
    repeat (2) frame(1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (o_y_pos !== 10'd391 || o_vy !== 4'd8 || o_state !== 2'd1) begin
      n_bad++;
      $display("FAIL third_jump_ignored: y=%0d vy=%0d st=%0d, want 391 8 1",
               o_y_pos, o_vy, o_state);
    end
    repeat (40) frame(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_y_pos !== 10'd475 || o_state !== 2'd0) begin
      n_bad++;
      $display("FAIL double_jump_land: y=%0d st=%0d, want 475 0", o_y_pos, o_state);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_walk();
    test_jump_pulse();
`ifdef SPRITE_MOTION_DOUBLE_JUMP_EN
    test_double_jump();
`else
    test_jump_held();
`endif
    test_reset_midjump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
